// File: rtl/axis_lite_master_bridge_if.sv
// rtl/axis_lite_master_bridge_if.sv - stream and AXI-Lite signal bundle for the bridge
interface axis_lite_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  logic [ADDR_WIDTH-1:0]   m_axil_awaddr;
  logic                    m_axil_awvalid;
  logic                    m_axil_awready;
  logic [DATA_WIDTH-1:0]   m_axil_wdata;
  logic [DATA_WIDTH/8-1:0] m_axil_wstrb;
  logic                    m_axil_wvalid;
  logic                    m_axil_wready;
  logic [1:0]              m_axil_bresp;
  logic                    m_axil_bvalid;
  logic                    m_axil_bready;
  logic [ADDR_WIDTH-1:0]   m_axil_araddr;
  logic                    m_axil_arvalid;
  logic                    m_axil_arready;
  logic [DATA_WIDTH-1:0]   m_axil_rdata;
  logic [1:0]              m_axil_rresp;
  logic                    m_axil_rvalid;
  logic                    m_axil_rready;

  // Bridge side: consumes s_axis, produces m_axis, masters the AXI-Lite bus.
  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output m_axil_awaddr, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    output m_axil_araddr, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  m_axil_awaddr, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    input  m_axil_araddr, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/axis_lite_master_bridge.sv
// rtl/axis_lite_master_bridge.sv - AXI-Lite master turning stream beats into writes and reads into stream beats
module axis_lite_master_bridge #(
  parameter int                      AXI_DATA_WIDTH = 32,
  parameter int                      AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR     = 32'h0000_0001
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          rd_enable,
  output logic [7:0]                    err_count,
  axis_lite_master_bridge_if.master     bus
);

  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                    state, state_nxt;
  logic                      last_wr;
  logic                      aw_done, w_done;
  logic                      slot_valid;
  logic [AXI_DATA_WIDTH-1:0] slot_data;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [7:0]                err_q;

  logic wr_req, rd_req, grant_wr, grant_rd;
  logic aw_hs, w_hs, wr_both_done, err_inc;
  logic s_tready, awvalid, wvalid, bready, arvalid, rready;

  assign wr_req   = bus.s_axis_tvalid;
  assign rd_req   = rd_enable & ~slot_valid;
  // On conflict the type that lost last time wins; last_wr resets to 0 so write wins first.
  assign grant_wr = wr_req & (~rd_req | ~last_wr);
  assign grant_rd = rd_req & (~wr_req | last_wr);

  assign aw_hs        = (state == WRITE) & ~aw_done & bus.m_axil_awready;
  assign w_hs         = (state == WRITE) & ~w_done & bus.m_axil_wready;
  assign wr_both_done = (aw_done | aw_hs) & (w_done | w_hs);

  assign err_inc = ((state == WR_RESP) & bus.m_axil_bvalid & (bus.m_axil_bresp != 2'b00)) |
                   ((state == RD_DATA) & bus.m_axil_rvalid & (bus.m_axil_rresp != 2'b00));

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          // Gated by reset so an upstream beat is never consumed during reset.
          s_tready  = ~areset;
          state_nxt = WRITE;
        end else if (grant_rd) begin
          state_nxt = RD_ADDR;
        end
      end
      WRITE: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if (wr_both_done) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bus.m_axil_bvalid) state_nxt = IDLE;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (bus.m_axil_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (bus.m_axil_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      last_wr    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      slot_valid <= 1'b0;
      slot_data  <= '0;
      wdata_q    <= '0;
      err_q      <= 8'd0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && grant_wr) begin
        wdata_q <= bus.s_axis_tdata;
        last_wr <= 1'b1;
      end else if (state == IDLE && grant_rd) begin
        last_wr <= 1'b0;
      end

      if (state == WRITE) begin
        if (wr_both_done) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end

      // Reads are only issued with the slot empty, so load and drain never collide.
      if (slot_valid && bus.m_axis_tready) slot_valid <= 1'b0;
      if (state == RD_DATA && bus.m_axil_rvalid && bus.m_axil_rresp == 2'b00) begin
        slot_valid <= 1'b1;
        slot_data  <= bus.m_axil_rdata;
      end

      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign err_count          = err_q;
  assign bus.s_axis_tready  = s_tready;
  assign bus.m_axis_tdata   = slot_data;
  assign bus.m_axis_tvalid  = slot_valid;
  assign bus.m_axil_awaddr  = AXI_ADDR;
  assign bus.m_axil_awvalid = awvalid;
  assign bus.m_axil_wdata   = wdata_q;
  assign bus.m_axil_wstrb   = '1;
  assign bus.m_axil_wvalid  = wvalid;
  assign bus.m_axil_bready  = bready;
  assign bus.m_axil_araddr  = AXI_ADDR;
  assign bus.m_axil_arvalid = arvalid;
  assign bus.m_axil_rready  = rready;

endmodule

// File: tb/tb_axis_lite_master_bridge.sv
// tb/tb_axis_lite_master_bridge.sv - directed self-checking bench for axis_lite_master_bridge
module tb_axis_lite_master_bridge;
  localparam int DW = 32;
  localparam int AW = 32;

  logic       aclk = 1'b0;
  logic       areset;
  logic       rd_enable;
  logic [7:0] err_count;

  axis_lite_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axis_lite_master_bridge #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_ADDR(32'h0000_0001)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .rd_enable(rd_enable),
    .err_count(err_count),
    .bus(bus.master)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  // {awvalid, wvalid, arvalid, m_axis_tvalid, s_axis_tready, bready, rready}
  logic [6:0] ctl;
  assign ctl = {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axis_tvalid,
                bus.s_axis_tready, bus.m_axil_bready, bus.m_axil_rready};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_all(input logic [7:0] v);
    {bus.s_axis_tvalid, rd_enable, bus.m_axil_awready, bus.m_axil_wready,
     bus.m_axil_bvalid, bus.m_axil_arready, bus.m_axil_rvalid, bus.m_axis_tready} = v;
  endtask

  initial begin
    int  cnt;
    int  hold;
    int  ng;
    int  comp;
    logic prev_aw, prev_ar, mid_done;
    logic gw [20];

    areset = 1'b1;
    drive_all(8'h00);
    bus.s_axis_tdata = '0;
    bus.m_axil_bresp = 2'b00;
    bus.m_axil_rresp = 2'b00;
    bus.m_axil_rdata = '0;

    // 1. reset held three edges with inputs toggling
    for (int i = 0; i < 3; i++) begin
      step();
      drive_all((i % 2 == 0) ? 8'hFF : 8'h55);
      bus.s_axis_tdata = 32'hC0DE_0000 + i;
      bus.m_axil_bresp = 2'b10;
      bus.m_axil_rresp = 2'b10;
      #1;
      check("rst_ctl", ctl, 7'b0);
      check("rst_err", err_count, 8'd0);
    end
    areset = 1'b0;
    drive_all(8'h00);
    bus.m_axil_bresp = 2'b00;
    bus.m_axil_rresp = 2'b00;
    #1;
    check("post_rst_ctl", ctl, 7'b0);
    step();
    check("post_rst_ctl2", ctl, 7'b0);

    // 2. single write, zero-wait slave
    bus.m_axil_awready = 1'b1;
    bus.m_axil_wready  = 1'b1;
    bus.m_axil_bvalid  = 1'b1;
    bus.s_axis_tdata   = 32'hDEAD_BEEF;
    bus.s_axis_tvalid  = 1'b1;
    #1;
    check("wr_tready", bus.s_axis_tready, 1'b1);
    step();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    #1;
    check("wr_ctl_aw_w", ctl, 7'b1100000);
    check("wr_awaddr", bus.m_axil_awaddr, 32'h1);
    check("wr_wdata", bus.m_axil_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", bus.m_axil_wstrb, 4'hF);
    step();
    check("wr_ctl_b", ctl, 7'b0000010);
    step();
    check("wr_ctl_idle", ctl, 7'b0);
    check("wr_err", err_count, 8'd0);
    bus.m_axil_bvalid = 1'b0;

    // 3. skewed write: W accepted immediately, AW three cycles later, SLVERR
    bus.m_axil_awready = 1'b0;
    bus.s_axis_tdata   = 32'h1234_5678;
    bus.s_axis_tvalid  = 1'b1;
    #1;
    check("skew_tready", bus.s_axis_tready, 1'b1);
    step();
    bus.s_axis_tvalid = 1'b0;
    #1;
    check("skew_c1", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 3'b110);
    check("skew_wdata", bus.m_axil_wdata, 32'h1234_5678);
    step();
    check("skew_c2", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 3'b100);
    step();
    check("skew_c3", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 3'b100);
    step();
    bus.m_axil_awready = 1'b1;
    #1;
    check("skew_c4", {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_bready}, 3'b100);
    step();
    bus.m_axil_bvalid = 1'b1;
    bus.m_axil_bresp  = 2'b10;
    #1;
    check("skew_resp", ctl, 7'b0000010);
    step();
    bus.m_axil_bvalid = 1'b0;
    bus.m_axil_bresp  = 2'b00;
    #1;
    check("skew_idle", ctl, 7'b0);
    check("skew_err", err_count, 8'd1);

    // 4. reads with a held-off consumer
    bus.m_axil_arready = 1'b1;
    bus.m_axil_rvalid  = 1'b1;
    bus.m_axis_tready  = 1'b0;
    rd_enable          = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.m_axil_rdata = k;
      #1;
      cnt = 0;
      while (!bus.m_axis_tvalid && cnt < 10) begin
        if (bus.m_axil_arvalid) check("rd_araddr", bus.m_axil_araddr, 32'h1);
        step();
        cnt++;
      end
      check("rd_latency", cnt, 3);
      hold = (k == 1) ? 5 : 1;
      for (int h = 0; h < hold; h++) begin
        check("rd_hold_arvalid", bus.m_axil_arvalid, 1'b0);
        check("rd_hold_tvalid", bus.m_axis_tvalid, 1'b1);
        check("rd_hold_tdata", bus.m_axis_tdata, k);
        step();
      end
      bus.m_axis_tready = 1'b1;
      #1;
      check("rd_pop_tdata", bus.m_axis_tdata, k);
      step();
      bus.m_axis_tready = 1'b0;
      if (k == 3) rd_enable = 1'b0;
    end
    #1;
    check("rd_drained", ctl, 7'b0);

    // 5. continuous conflict: grants must alternate starting with write
    bus.m_axil_awready = 1'b1;
    bus.m_axil_wready  = 1'b1;
    bus.m_axil_bvalid  = 1'b1;
    bus.m_axil_arready = 1'b1;
    bus.m_axil_rvalid  = 1'b1;
    bus.m_axis_tready  = 1'b1;
    bus.s_axis_tdata   = 32'hA5A5_5A5A;
    bus.s_axis_tvalid  = 1'b1;
    rd_enable          = 1'b1;
    ng      = 0;
    prev_aw = 1'b0;
    prev_ar = 1'b0;
    for (int c = 0; c < 200 && ng < 20; c++) begin
      step();
      if (bus.m_axil_awvalid && !prev_aw) begin
        gw[ng] = 1'b1;
        ng++;
      end else if (bus.m_axil_arvalid && !prev_ar) begin
        gw[ng] = 1'b0;
        ng++;
      end
      prev_aw = bus.m_axil_awvalid;
      prev_ar = bus.m_axil_arvalid;
    end
    check("conf_grants", ng, 20);
    for (int i = 0; i < ng; i++) check($sformatf("conf_grant%0d", i), gw[i], (i % 2 == 0));
    bus.s_axis_tvalid = 1'b0;
    rd_enable         = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("conf_quiet", ctl, 7'b0);
    check("conf_err", err_count, 8'd1);

    // 6. reset while waiting for B, then saturating read errors
    bus.m_axil_bvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    #1;
    check("mid_tready", bus.s_axis_tready, 1'b1);
    step();
    bus.s_axis_tvalid = 1'b0;
    step();
    check("mid_wresp", ctl, 7'b0000010);
    areset = 1'b1;
    step();
    check("mid_rst_ctl", ctl, 7'b0);
    check("mid_rst_err", err_count, 8'd0);
    areset = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    #1;
    check("mid_idle_grant", bus.s_axis_tready, 1'b1);
    bus.s_axis_tvalid = 1'b0;
    #1;
    check("mid_idle_nogrant", bus.s_axis_tready, 1'b0);

    bus.m_axil_rresp = 2'b10;
    rd_enable        = 1'b1;
    comp     = 0;
    mid_done = 1'b0;
    for (int c = 0; c < 2000 && comp < 300; c++) begin
      if (bus.m_axil_rready) comp++;
      step();
      if (comp == 200 && !mid_done) begin
        check("sat_err_200", err_count, 8'd200);
        mid_done = 1'b1;
      end
    end
    rd_enable = 1'b0;
    step();
    step();
    check("sat_reads", comp, 300);
    check("sat_err", err_count, 8'd255);
    check("sat_no_data", bus.m_axis_tvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
